// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter granting the Common Data Bus to one FU per cycle.
// Optional macro CDB_STALL_CNT_EN adds per-FU saturating stall counters on port stall_cnt.
module cdb_arbiter #(
  parameter int N_UNITS = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6,
  parameter int STALL_W = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [N_UNITS-1:0]          unit_rts,
  input  logic [N_UNITS*DATA_W-1:0]   unit_data,
  input  logic [N_UNITS*TAG_W-1:0]    unit_source,
  output logic [N_UNITS-1:0]          unit_xmit,
  output logic [DATA_W-1:0]           CDB_data,
  output logic [TAG_W-1:0]            CDB_source,
  output logic                        CDB_write,
  output logic [$clog2(N_UNITS)-1:0]  grant_id,
  output logic                        error
`ifdef CDB_STALL_CNT_EN
  ,
  output logic [N_UNITS*STALL_W-1:0]  stall_cnt
`endif
);

  localparam int IDX_W = $clog2(N_UNITS);

  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   last_grant_r;
  logic               last_grant_valid_r;

  logic [N_UNITS-1:0] eligible_s;
  logic [N_UNITS-1:0] win_onehot_s;
  logic               win_found_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [DATA_W-1:0]  win_data_s;
  logic [TAG_W-1:0]   win_source_s;
  logic               win_tag_ok_s;
  logic [IDX_W-1:0]   rr_next_s;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= N_UNITS) begin
      sum = sum - N_UNITS;
    end else begin
      sum = sum;
    end
    return IDX_W'(sum);
  endfunction

  // Previous winner is masked for one cycle while it is still dropping rts.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      eligible_s[i] = unit_rts[i] & ~(last_grant_valid_r & (last_grant_r == IDX_W'(i)));
    end
  end

  // Round-robin scan starting at rr_ptr; first eligible index wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      win_idx_s   = (eligible_s[wrap_add(rr_ptr_r, k)] && !win_found_s) ? wrap_add(rr_ptr_r, k) : win_idx_s;
      win_found_s = win_found_s | eligible_s[wrap_add(rr_ptr_r, k)];
    end
    win_data_s             = unit_data[int'(win_idx_s)*DATA_W +: DATA_W];
    win_source_s           = unit_source[int'(win_idx_s)*TAG_W +: TAG_W];
    win_tag_ok_s           = (win_source_s != TAG_W'(0));
    win_onehot_s           = '0;
    win_onehot_s[win_idx_s] = win_found_s;
    rr_next_s              = (win_idx_s == IDX_W'(N_UNITS - 1)) ? IDX_W'(0) : win_idx_s + IDX_W'(1);
  end

  // Registered broadcast, grant and arbitration state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      unit_xmit          <= '0;
      CDB_data           <= '0;
      CDB_source         <= '0;
      CDB_write          <= 1'b0;
      grant_id           <= '0;
      error              <= 1'b0;
      rr_ptr_r           <= '0;
      last_grant_r       <= '0;
      last_grant_valid_r <= 1'b0;
    end else if (win_found_s) begin
      unit_xmit          <= win_onehot_s;
      CDB_data           <= win_data_s;
      CDB_source         <= win_source_s;
      // A tag-0 winner still drains via xmit but never reaches the bus.
      CDB_write          <= win_tag_ok_s;
      grant_id           <= win_idx_s;
      error              <= error | ~win_tag_ok_s;
      rr_ptr_r           <= rr_next_s;
      last_grant_r       <= win_idx_s;
      last_grant_valid_r <= 1'b1;
    end else begin
      unit_xmit          <= '0;
      CDB_write          <= 1'b0;
      last_grant_valid_r <= 1'b0;
    end
  end

`ifdef CDB_STALL_CNT_EN
  // Per-FU saturating count of cycles spent requesting without a grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N_UNITS; i++) begin
        if (win_found_s && (win_idx_s == IDX_W'(i))) begin
          stall_cnt[i*STALL_W +: STALL_W] <= '0;
        end else if (unit_rts[i] && (stall_cnt[i*STALL_W +: STALL_W] != {STALL_W{1'b1}})) begin
          stall_cnt[i*STALL_W +: STALL_W] <= stall_cnt[i*STALL_W +: STALL_W] + STALL_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// against a behavioural model of the round-robin/mask rules.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 6;
  localparam int SW = 8;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    unit_rts = '0;
  logic [N*DW-1:0] unit_data = '0;
  logic [N*TW-1:0] unit_source = '0;
  logic [N-1:0]    unit_xmit;
  logic [DW-1:0]   CDB_data;
  logic [TW-1:0]   CDB_source;
  logic            CDB_write;
  logic [1:0]      grant_id;
  logic            error;
`ifdef CDB_STALL_CNT_EN
  logic [N*SW-1:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // model state
  int            m_rr;
  int            m_last;
  logic [N-1:0]  e_xmit;
  logic          e_write;
  logic          e_err;
  logic [DW-1:0] e_data;
  logic [TW-1:0] e_src;
  int            e_gid;
  int            m_stall [N];

  cdb_arbiter #(.N_UNITS(N), .DATA_W(DW), .TAG_W(TW), .STALL_W(SW)) dut (
    .clock(clock), .reset_n(reset_n), .unit_rts(unit_rts), .unit_data(unit_data),
    .unit_source(unit_source), .unit_xmit(unit_xmit), .CDB_data(CDB_data),
    .CDB_source(CDB_source), .CDB_write(CDB_write), .grant_id(grant_id), .error(error)
`ifdef CDB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fu(input int i, input logic rts, input logic [DW-1:0] d, input logic [TW-1:0] s);
    unit_rts[i] = rts;
    unit_data[i*DW +: DW] = d;
    unit_source[i*TW +: TW] = s;
  endtask

  task automatic model_reset();
    m_rr = 0; m_last = -1;
    e_xmit = '0; e_write = 1'b0; e_err = 1'b0; e_data = '0; e_src = '0; e_gid = 0;
    for (int i = 0; i < N; i++) m_stall[i] = 0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // Predict outputs after the next edge from current inputs.
  task automatic model_step();
    int w;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (w < 0 && unit_rts[i] && i != m_last) w = i;
    end
    for (int i = 0; i < N; i++) begin
      if (i == w) m_stall[i] = 0;
      else if (unit_rts[i] && m_stall[i] < 255) m_stall[i] = m_stall[i] + 1;
    end
    if (w >= 0) begin
      e_xmit = '0;
      e_xmit[w] = 1'b1;
      e_gid = w;
      e_data = unit_data[w*DW +: DW];
      e_src = unit_source[w*TW +: TW];
      e_write = (e_src != '0);
      if (e_src == '0) e_err = 1'b1;
      m_rr = (w + 1) % N;
      m_last = w;
    end else begin
      e_xmit = '0;
      e_write = 1'b0;
      m_last = -1;
    end
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (unit_xmit !== 4'b0000 || CDB_write !== 1'b0 || CDB_data !== 32'd0 ||
        CDB_source !== 6'd0 || grant_id !== 2'd0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got xmit=%b wr=%b data=%0d src=%0d gid=%0d err=%b want all 0",
               unit_xmit, CDB_write, CDB_data, CDB_source, grant_id, error);
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    pulse_reset();
    set_fu(0, 1'b1, 32'd10, 6'd1);
    tick();
    checks++;
    if (unit_xmit !== 4'b0001 || CDB_write !== 1'b1 || CDB_data !== 32'd10 || CDB_source !== 6'd1) begin
      errors++;
      $display("FAIL single_grant got xmit=%b wr=%b data=%0d src=%0d want 0001 1 10 1",
               unit_xmit, CDB_write, CDB_data, CDB_source);
    end
    set_fu(0, 1'b0, 32'd0, 6'd0);
    tick();
    checks++;
    if (unit_xmit !== 4'b0000 || CDB_write !== 1'b0 || CDB_data !== 32'd10 || CDB_source !== 6'd1) begin
      errors++;
      $display("FAIL single_idle got xmit=%b wr=%b data=%0d src=%0d want 0000 0 10 1 (held)",
               unit_xmit, CDB_write, CDB_data, CDB_source);
    end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    for (int i = 0; i < N; i++) set_fu(i, 1'b1, 32'(100 + i), 6'(i + 1));
    for (int c = 0; c < 6; c++) begin
      int w;
      logic [N-1:0] oh;
      w = c % N;
      oh = '0;
      oh[w] = 1'b1;
      tick();
      checks++;
      if (unit_xmit !== oh || grant_id !== 2'(w) || CDB_write !== 1'b1 ||
          CDB_source !== 6'(w + 1) || CDB_data !== 32'(100 + w)) begin
        errors++;
        $display("FAIL rr_cycle%0d got xmit=%b gid=%0d wr=%b src=%0d data=%0d want xmit=%b gid=%0d",
                 c, unit_xmit, grant_id, CDB_write, CDB_source, CDB_data, oh, w);
      end
    end
    unit_rts = '0;
  endtask

  task automatic test_lone();
    pulse_reset();
    set_fu(2, 1'b1, 32'd60, 6'd3);
    for (int c = 0; c < 4; c++) begin
      logic [N-1:0] want;
      want = (c % 2 == 0) ? 4'b0100 : 4'b0000;
      tick();
      checks++;
      if (unit_xmit !== want) begin
        errors++;
        $display("FAIL lone_cycle%0d got xmit=%b want %b", c, unit_xmit, want);
      end
    end
    unit_rts = '0;
  endtask

  task automatic test_illegal_tag();
    pulse_reset();
    set_fu(1, 1'b1, 32'd5, 6'd0);
    tick();
    checks++;
    if (unit_xmit !== 4'b0010 || CDB_write !== 1'b0 || error !== 1'b1) begin
      errors++;
      $display("FAIL illegal_tag got xmit=%b wr=%b err=%b want 0010 0 1", unit_xmit, CDB_write, error);
    end
    set_fu(1, 1'b0, 32'd0, 6'd0);
    set_fu(0, 1'b1, 32'd7, 6'd9);
    tick();
    checks++;
    if (unit_xmit !== 4'b0001 || CDB_write !== 1'b1 || error !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky got xmit=%b wr=%b err=%b want 0001 1 1", unit_xmit, CDB_write, error);
    end
    unit_rts = '0;
    tick();
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky_idle got err=%b want 1", error);
    end
    pulse_reset();
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL error_clear got err=%b want 0", error);
    end
  endtask

  task automatic test_reset_mid_grant();
    pulse_reset();
    set_fu(3, 1'b1, 32'd33, 6'd4);
    tick();
    checks++;
    if (unit_xmit !== 4'b1000) begin
      errors++;
      $display("FAIL mid_pre got xmit=%b want 1000", unit_xmit);
    end
    set_fu(0, 1'b1, 32'd11, 6'd2);
    reset_n = 1'b0;
    #1;
    checks++;
    if (unit_xmit !== 4'b0000 || CDB_write !== 1'b0 || CDB_data !== 32'd0 || CDB_source !== 6'd0) begin
      errors++;
      $display("FAIL mid_async got xmit=%b wr=%b data=%0d src=%0d want all 0",
               unit_xmit, CDB_write, CDB_data, CDB_source);
    end
    #1;
    reset_n = 1'b1;
    model_reset();
    tick();
    checks++;
    if (unit_xmit !== 4'b0001 || CDB_data !== 32'd11) begin
      errors++;
      $display("FAIL mid_restart got xmit=%b data=%0d want 0001 11", unit_xmit, CDB_data);
    end
    tick();
    checks++;
    if (unit_xmit !== 4'b1000 || CDB_source !== 6'd4) begin
      errors++;
      $display("FAIL mid_next got xmit=%b src=%0d want 1000 4", unit_xmit, CDB_source);
    end
    unit_rts = '0;
  endtask

`ifdef CDB_STALL_CNT_EN
  task automatic test_stall();
    pulse_reset();
    for (int i = 0; i < N; i++) set_fu(i, 1'b1, 32'(i), 6'(i + 1));
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (stall_cnt[3*SW +: SW] !== 8'd3 || unit_xmit[3] !== 1'b0) begin
      errors++;
      $display("FAIL stall_pre got cnt=%0d xmit=%b want 3 with xmit[3]=0", stall_cnt[3*SW +: SW], unit_xmit);
    end
    tick();
    checks++;
    if (stall_cnt[3*SW +: SW] !== 8'd0 || unit_xmit !== 4'b1000) begin
      errors++;
      $display("FAIL stall_clear got cnt=%0d xmit=%b want 0 1000", stall_cnt[3*SW +: SW], unit_xmit);
    end
    unit_rts = '0;
  endtask
`endif

  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        set_fu(i, 1'($urandom_range(0, 1)), $urandom,
               ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63)));
      end
      model_step();
      tick();
      checks++;
      if (unit_xmit !== e_xmit || CDB_write !== e_write || error !== e_err ||
          CDB_data !== e_data || CDB_source !== e_src) begin
        errors++;
        $display("FAIL rand_c%0d got xmit=%b wr=%b err=%b data=%h src=%0d want xmit=%b wr=%b err=%b data=%h src=%0d",
                 c, unit_xmit, CDB_write, error, CDB_data, CDB_source, e_xmit, e_write, e_err, e_data, e_src);
      end
      if (e_xmit != '0) begin
        checks++;
        if (grant_id !== 2'(e_gid)) begin
          errors++;
          $display("FAIL rand_gid_c%0d got %0d want %0d", c, grant_id, e_gid);
        end
      end
`ifdef CDB_STALL_CNT_EN
      for (int i = 0; i < N; i++) begin
        checks++;
        if (stall_cnt[i*SW +: SW] !== 8'(m_stall[i])) begin
          errors++;
          $display("FAIL rand_stall_c%0d_fu%0d got %0d want %0d", c, i, stall_cnt[i*SW +: SW], m_stall[i]);
        end
      end
`endif
      if ($urandom_range(0, 49) == 0) pulse_reset();
    end
    unit_rts = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lone();
    test_illegal_tag();
    test_reset_mid_grant();
`ifdef CDB_STALL_CNT_EN
    test_stall();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
